// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the SC CPU fetch/execute sequencer.
//   state_e          : sequencer state encoding (3 bits)
//   WdtLimitDefault  : default watchdog limit in wait cycles (0 disables)
//   IrResetDefault   : default reset/idle value of the instruction register
//   wdt_width()      : watchdog counter width for a given limit
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StMem,
    StHalt,
    StFault
  } state_e;

  localparam int unsigned WdtLimitDefault = 255;
  localparam logic [7:0]  IrResetDefault  = 8'h00;

  // clog2(limit+1), but never narrower than one bit so a disabled watchdog still elaborates.
  function automatic int unsigned wdt_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/seq_wdt.sv
// Wait-cycle watchdog shared by the FETCH and MEM states.
//   clk_i     : clock
//   rst_i     : asynchronous reset, active-high
//   clr_i     : restart the count (state entry); wins over en_i
//   en_i      : a wait cycle is being spent
//   timeout_o : this wait cycle is the Limit-th one in a row
// A Limit of 0 disables the watchdog entirely.
module seq_wdt
  import cpu_seq_pkg::*;
#(
  parameter int unsigned Limit = WdtLimitDefault
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int unsigned Width = wdt_width(Limit);
  localparam logic [Width-1:0] LastCnt = Width'((Limit == 0) ? 0 : Limit - 1);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (Limit != 0) && (cnt_q != LastCnt)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count equals the number of wait cycles already spent, so reaching LastCnt while still
  // waiting means this is the Limit-th wait cycle.
  assign timeout_o = (Limit != 0) && en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/execute sequencer for the 8-bit SC CPU.
// Fetches into INST over a valid handshake, turns the control unit's write enables into
// single-cycle commit strobes, stalls on data memory, and handles halt, run/stop and
// watchdog fault.
// Optional feature: define SEQ_SINGLE_STEP_EN to let a STEP pulse in IDLE (RUN=0) run
// exactly one instruction; otherwise STEP is ignored.
// Ports:
//   CLK, RST                  : clock, asynchronous active-high reset
//   RUN, STEP                 : continuous-run level, single-step pulse
//   IMEM_REQ/VLD/DATA         : instruction fetch handshake
//   INST                      : instruction register, to control unit
//   CU_*                      : control-unit decode of INST
//   DMEM_REQ/RDY              : data-memory access handshake
//   REG_W_STB .. PC_LD        : commit strobes
//   HALTED, FAULT             : terminal states, left only via RST
module cpu_seq_ctrl
  import cpu_seq_pkg::*;
#(
  parameter int unsigned WDT_LIMIT = WdtLimitDefault,
  parameter logic [7:0]  IR_RESET  = IrResetDefault
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
  output logic       IMEM_REQ,
  input  logic       IMEM_VLD,
  input  logic [7:0] IMEM_DATA,
  output logic [7:0] INST,
  input  logic       CU_REG_W_EN,
  input  logic       CU_FLAG_W,
  input  logic       CU_DMEM_W_EN,
  input  logic       CU_MEM_ACC,
  input  logic       CU_PC_LD_EN,
  input  logic       CU_PC_EN,
  output logic       DMEM_REQ,
  input  logic       DMEM_RDY,
  output logic       REG_W_STB,
  output logic       FLAG_W_STB,
  output logic       DMEM_W_STB,
  output logic       PC_INC,
  output logic       PC_LD,
  output logic       HALTED,
  output logic       FAULT,
  input  logic       STEP
);

  state_e     state_q, state_d;
  logic [7:0] inst_q, inst_d;
  logic       commit;
  logic       wdt_en, wdt_clr, wdt_timeout;

  always_comb begin
    state_d  = state_q;
    inst_d   = inst_q;
    IMEM_REQ = 1'b0;
    DMEM_REQ = 1'b0;
    commit   = 1'b0;
    wdt_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (RUN) begin
          state_d = StFetch;
`ifdef SEQ_SINGLE_STEP_EN
        end else if (STEP) begin
          // RUN is low, so the commit of this pass falls back to IDLE by itself.
          state_d = StFetch;
`endif
        end
      end
      StFetch: begin
        IMEM_REQ = 1'b1;
        if (IMEM_VLD) begin
          inst_d  = IMEM_DATA;
          state_d = StExec;
        end else begin
          wdt_en = 1'b1;
          if (wdt_timeout) state_d = StFault;
        end
      end
      StExec: begin
        if (!CU_PC_EN) begin
          state_d = StHalt;
        end else if (CU_MEM_ACC) begin
          state_d = StMem;
        end else begin
          commit  = 1'b1;
          state_d = RUN ? StFetch : StIdle;
        end
      end
      StMem: begin
        DMEM_REQ = 1'b1;
        if (DMEM_RDY) begin
          commit  = 1'b1;
          state_d = RUN ? StFetch : StIdle;
        end else begin
          wdt_en = 1'b1;
          if (wdt_timeout) state_d = StFault;
        end
      end
      StHalt, StFault: ;
      default: state_d = StIdle;
    endcase
    // Restart the watchdog on every state change.
    wdt_clr = (state_d != state_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      inst_q  <= IR_RESET;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
    end
  end

  seq_wdt #(
    .Limit(WDT_LIMIT)
  ) u_wdt (
    .clk_i    (CLK),
    .rst_i    (RST),
    .clr_i    (wdt_clr),
    .en_i     (wdt_en),
    .timeout_o(wdt_timeout)
  );

`ifndef SEQ_SINGLE_STEP_EN
  logic unused_step;
  assign unused_step = STEP;
`endif

  assign REG_W_STB  = commit & CU_REG_W_EN;
  assign FLAG_W_STB = commit & CU_FLAG_W;
  assign DMEM_W_STB = commit & (state_q == StMem) & CU_DMEM_W_EN;
  assign PC_LD      = commit & CU_PC_LD_EN;
  assign PC_INC     = commit & ~CU_PC_LD_EN;
  assign HALTED     = (state_q == StHalt);
  assign FAULT      = (state_q == StFault);
  assign INST       = inst_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: the stimulus process queues the expected commit /
// halt / fault events, a negedge monitor pops and compares whenever the DUT presents one.
module tb_cpu_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RUN = 1'b0;
  logic       IMEM_VLD = 1'b0;
  logic [7:0] IMEM_DATA = 8'h00;
  logic       CU_REG_W_EN = 1'b0;
  logic       CU_FLAG_W = 1'b0;
  logic       CU_DMEM_W_EN = 1'b0;
  logic       CU_MEM_ACC = 1'b0;
  logic       CU_PC_LD_EN = 1'b0;
  logic       CU_PC_EN = 1'b1;
  logic       DMEM_RDY = 1'b0;
  logic       STEP = 1'b0;
  logic       IMEM_REQ, DMEM_REQ, REG_W_STB, FLAG_W_STB, DMEM_W_STB, PC_INC, PC_LD;
  logic       HALTED, FAULT;
  logic [7:0] INST;

  always #5 CLK = ~CLK;

  cpu_seq_ctrl #(
    .WDT_LIMIT(4),
    .IR_RESET (8'h00)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RUN         (RUN),
    .IMEM_REQ    (IMEM_REQ),
    .IMEM_VLD    (IMEM_VLD),
    .IMEM_DATA   (IMEM_DATA),
    .INST        (INST),
    .CU_REG_W_EN (CU_REG_W_EN),
    .CU_FLAG_W   (CU_FLAG_W),
    .CU_DMEM_W_EN(CU_DMEM_W_EN),
    .CU_MEM_ACC  (CU_MEM_ACC),
    .CU_PC_LD_EN (CU_PC_LD_EN),
    .CU_PC_EN    (CU_PC_EN),
    .DMEM_REQ    (DMEM_REQ),
    .DMEM_RDY    (DMEM_RDY),
    .REG_W_STB   (REG_W_STB),
    .FLAG_W_STB  (FLAG_W_STB),
    .DMEM_W_STB  (DMEM_W_STB),
    .PC_INC      (PC_INC),
    .PC_LD       (PC_LD),
    .HALTED      (HALTED),
    .FAULT       (FAULT),
    .STEP        (STEP)
  );

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] inst;
    logic       reg_w;
    logic       flag_w;
    logic       dmem_w;
    logic       inc;
    logic       ld;
    logic [7:0] dreq;  // DMEM_REQ cycles up to and including the commit cycle
  } exp_t;

  localparam logic [1:0] KCommit = 2'd0;
  localparam logic [1:0] KHalt   = 2'd1;
  localparam logic [1:0] KFault  = 2'd2;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endfunction

  task automatic push(input logic [1:0] kind, input logic [7:0] inst, input logic r,
                      input logic f, input logic d, input logic i, input logic l,
                      input logic [7:0] dreq);
    exp_t e;
    e = '{kind: kind, inst: inst, reg_w: r, flag_w: f, dmem_w: d, inc: i, ld: l, dreq: dreq};
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Monitor
  exp_t       mon_e;
  logic [7:0] mon_dreq_cnt;
  logic       mon_halted_prev, mon_fault_prev;

  task automatic pop_event(input logic [1:0] kind, input string name);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got unexpected event, want none", name);
    end else begin
      mon_e = sb_q.pop_front();
      check(name, 32'(kind), 32'(mon_e.kind));
    end
  endtask

  initial begin
    mon_dreq_cnt    = '0;
    mon_halted_prev = 1'b0;
    mon_fault_prev  = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        mon_dreq_cnt    = '0;
        mon_halted_prev = 1'b0;
        mon_fault_prev  = 1'b0;
      end else begin
        if (DMEM_REQ) mon_dreq_cnt = mon_dreq_cnt + 8'd1;
        if (REG_W_STB | FLAG_W_STB | DMEM_W_STB | PC_INC | PC_LD) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_commit: got commit with INST %0h, want none", INST);
          end else begin
            mon_e = sb_q.pop_front();
            check("commit_kind", 32'(KCommit), 32'(mon_e.kind));
            check("commit_inst", 32'(INST), 32'(mon_e.inst));
            check("reg_w_stb", 32'(REG_W_STB), 32'(mon_e.reg_w));
            check("flag_w_stb", 32'(FLAG_W_STB), 32'(mon_e.flag_w));
            check("dmem_w_stb", 32'(DMEM_W_STB), 32'(mon_e.dmem_w));
            check("pc_inc", 32'(PC_INC), 32'(mon_e.inc));
            check("pc_ld", 32'(PC_LD), 32'(mon_e.ld));
            check("dmem_req_cycles", 32'(mon_dreq_cnt), 32'(mon_e.dreq));
          end
          mon_dreq_cnt = '0;
        end else if (!DMEM_REQ) begin
          mon_dreq_cnt = '0;
        end
        if (HALTED && !mon_halted_prev) pop_event(KHalt, "halt_event");
        if (FAULT && !mon_fault_prev) pop_event(KFault, "fault_event");
        mon_halted_prev = HALTED;
        mon_fault_prev  = FAULT;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: got no finish, want finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int waited;
    tick(2);
    check("rst_inst", 32'(INST), 32'h00);
    check("rst_outputs", 32'({IMEM_REQ, DMEM_REQ, REG_W_STB, FLAG_W_STB, DMEM_W_STB, PC_INC,
                              PC_LD, HALTED, FAULT}), 32'h0);
    RST = 1'b0;
    tick(1);
    check("idle_no_req", 32'(IMEM_REQ), 32'h0);

    // Two back-to-back ALU instructions with RUN held, RUN dropped in the second EXEC.
    RUN = 1'b1; IMEM_VLD = 1'b1; IMEM_DATA = 8'h31; CU_REG_W_EN = 1'b1;
    push(KCommit, 8'h31, 1, 0, 0, 1, 0, 8'd0);
    push(KCommit, 8'h31, 1, 0, 0, 1, 0, 8'd0);
    tick(1);
    check("fetch_req", 32'(IMEM_REQ), 32'h1);
    tick(1);
    check("inst_cycle2", 32'(INST), 32'h31);
    tick(1);
    check("fetch_follows", 32'(IMEM_REQ), 32'h1);
    tick(1);
    RUN = 1'b0;
    tick(1);
    check("alu_to_idle", 32'({IMEM_REQ, DMEM_REQ}), 32'h0);

    // Store with 3-cycle DMEM wait; RUN dropped during the wait.
    RUN = 1'b1; IMEM_DATA = 8'hA5; CU_REG_W_EN = 1'b0; CU_MEM_ACC = 1'b1; CU_DMEM_W_EN = 1'b1;
    push(KCommit, 8'hA5, 0, 0, 1, 1, 0, 8'd3);
    tick(3);
    check("mem_req", 32'(DMEM_REQ), 32'h1);
    RUN = 1'b0;
    tick(2);
    DMEM_RDY = 1'b1;
    tick(1);
    DMEM_RDY = 1'b0;
    check("mem_to_idle", 32'({IMEM_REQ, DMEM_REQ}), 32'h0);

    // Branch with flag write.
    CU_MEM_ACC = 1'b0; CU_DMEM_W_EN = 1'b0; CU_PC_LD_EN = 1'b1; CU_FLAG_W = 1'b1;
    IMEM_DATA = 8'hC7; RUN = 1'b1;
    push(KCommit, 8'hC7, 0, 1, 0, 0, 1, 8'd0);
    tick(1);
    RUN = 1'b0;
    tick(2);
    check("branch_to_idle", 32'(IMEM_REQ), 32'h0);

    // Fetch valid in the 4th wait cycle: no fault.
    CU_PC_LD_EN = 1'b0; CU_FLAG_W = 1'b0; CU_REG_W_EN = 1'b1; IMEM_VLD = 1'b0;
    IMEM_DATA = 8'h5A; RUN = 1'b1;
    push(KCommit, 8'h5A, 1, 0, 0, 1, 0, 8'd0);
    tick(1);
    RUN = 1'b0;
    tick(3);
    IMEM_VLD = 1'b1;
    tick(1);
    check("vld_beats_wdt", 32'(FAULT), 32'h0);
    check("late_inst", 32'(INST), 32'h5A);
    tick(1);

    // STEP pulse in IDLE with RUN=0.
    IMEM_DATA = 8'h12; STEP = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
    push(KCommit, 8'h12, 1, 0, 0, 1, 0, 8'd0);
    tick(1);
    STEP = 1'b0;
    check("step_fetch", 32'(IMEM_REQ), 32'h1);
    tick(3);
`else
    tick(1);
    STEP = 1'b0;
    check("step_ignored", 32'(IMEM_REQ), 32'h0);
    tick(3);
`endif
    check("step_back_idle", 32'(IMEM_REQ), 32'h0);

    // Halt: sticky with RUN=1, cleared by reset.
    CU_PC_EN = 1'b0; IMEM_DATA = 8'hFF; RUN = 1'b1;
    push(KHalt, 8'h00, 0, 0, 0, 0, 0, 8'd0);
    tick(3);
    check("halted", 32'(HALTED), 32'h1);
    tick(3);
    check("halt_sticky", 32'({HALTED, IMEM_REQ, DMEM_REQ}), 32'h4);
    RST = 1'b1; RUN = 1'b0;
    #1;
    check("halt_rst_inst", 32'(INST), 32'h00);
    check("halt_rst_state", 32'(HALTED), 32'h0);
    tick(1);
    RST = 1'b0;
    tick(1);
    check("post_rst_idle", 32'(IMEM_REQ), 32'h0);

    // Watchdog fault: IMEM never valid.
    CU_PC_EN = 1'b1; IMEM_VLD = 1'b0; RUN = 1'b1;
    push(KFault, 8'h00, 0, 0, 0, 0, 0, 8'd0);
    tick(1);
    RUN = 1'b0;
    tick(3);
    check("wdt_4th_cycle", 32'({FAULT, IMEM_REQ}), 32'h1);
    tick(1);
    check("wdt_fault", 32'(FAULT), 32'h1);
    tick(2);
    check("fault_sticky", 32'({FAULT, IMEM_REQ}), 32'h2);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    tick(1);
    check("fault_cleared", 32'(FAULT), 32'h0);

    waited = 0;
    while (sb_q.size() != 0 && waited < 20) begin
      tick(1);
      waited++;
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Multi-cycle fetch/execute sequencer for the 8-bit SC CPU.
- Fetches each instruction over a valid-handshake instruction-memory port and holds it in the instruction register (INST). INST feeds the combinational control unit.
- Gates that unit's write enables into single-cycle commit strobes.
- Stalls on data-memory accesses until the memory is ready.
- Handles halt, run/stop and watchdog fault.

Parameters:
WDT_LIMIT, 255, maximum wait cycles in FETCH or MEM before FAULT; 0 disables the watchdog.
IR_RESET, 8'h00, reset and idle value of INST.

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous reset, active-high
RUN  in  1  level; 1 = execute continuously
IMEM_REQ  out  1  instruction fetch request
IMEM_VLD  in  1  instruction data valid
IMEM_DATA  in  8  instruction byte
INST  out  8  instruction register, to control unit
CU_REG_W_EN  in  1  control-unit register write enable
CU_FLAG_W  in  1  control-unit flag write
CU_DMEM_W_EN  in  1  control-unit data-memory write
CU_MEM_ACC  in  1  instruction reads or writes data memory
CU_PC_LD_EN  in  1  branch/jump taken
CU_PC_EN  in  1  0 = halt instruction
DMEM_REQ  out  1  data-memory access request
DMEM_RDY  in  1  data-memory access complete
REG_W_STB  out  1  register-file write strobe
FLAG_W_STB  out  1  flag-register write strobe
DMEM_W_STB  out  1  data-memory write strobe
PC_INC  out  1  PC increment strobe
PC_LD  out  1  PC load strobe
HALTED  out  1  halt state reached
FAULT  out  1  watchdog fault, sticky
STEP  in  1  single-step pulse (used only with the optional feature)

Behaviour:
- Clocking and reset: one clock (CLK); reset RST is asynchronous and active-high. On RST: state IDLE, INST=IR_RESET, watchdog count 0. All outputs are 0.
- Registered vs combinational: state, INST and the watchdog count are registered. Strobes, IMEM_REQ and DMEM_REQ are combinational from the current state and inputs. At most one commit per instruction.
- IDLE: all strobes 0. If RUN=1, next state is FETCH.
- FETCH:
  - IMEM_REQ=1, held until IMEM_VLD.
  - On IMEM_VLD: INST<=IMEM_DATA; next state EXEC.
  - Otherwise the watchdog increments; after WDT_LIMIT cycles without VLD, go to FAULT.
  - If VLD and timeout coincide, VLD wins.
- EXEC (1 cycle, control unit decodes INST):
  - CU_PC_EN=0: go to HALT; no strobes.
  - Else if CU_MEM_ACC=1: go to MEM; no strobes.
  - Else commit this cycle:
    - REG_W_STB=CU_REG_W_EN, FLAG_W_STB=CU_FLAG_W.
    - PC_LD=CU_PC_LD_EN, PC_INC=~CU_PC_LD_EN.
    - Next state is FETCH if RUN=1, else IDLE.
- MEM:
  - DMEM_REQ=1, held until DMEM_RDY.
  - In the cycle DMEM_RDY=1, commit as in EXEC, plus DMEM_W_STB=CU_DMEM_W_EN. Next state is FETCH or IDLE, selected by RUN.
  - The watchdog applies as in FETCH.
- Latency: non-memory instruction = 2 cycles with zero-wait IMEM; memory instruction = 3 cycles with zero-wait memories.
- HALT: HALTED=1; exits only on RST.
- FAULT: FAULT=1; exits only on RST. In HALT and FAULT, all strobes and requests are 0.
- RUN deasserted mid-instruction: the current instruction completes and commits, then the sequencer goes to IDLE.
- Watchdog: the count clears on every state entry. The counter width is clog2(WDT_LIMIT+1).

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- Defined: in IDLE with RUN=0, a STEP=1 cycle starts exactly one FETCH/EXEC(/MEM) pass, then returns to IDLE. STEP in other states is ignored.
- Undefined: STEP is ignored; behaviour is identical to RUN-only.

Decomposition:
- Package cpu_seq_pkg:
  - state enum: IDLE, FETCH, EXEC, MEM, HALT, FAULT (3-bit encoding)
  - WDT_LIMIT default
  - IR_RESET default
- Sub-module seq_wdt: clear/enable/limit counter with a timeout output; one instance is shared by FETCH and MEM.

Test Plan:
- Reset, then RUN=1, IMEM_VLD immediate, IMEM_DATA=8'h31, CU_REG_W_EN=1, CU_MEM_ACC=0 -> INST=8'h31 at cycle 2; REG_W_STB and PC_INC pulse 1 cycle in EXEC; FETCH follows.
- Memory store: CU_MEM_ACC=1, CU_DMEM_W_EN=1, DMEM_RDY after 3 cycles -> DMEM_REQ high 3 cycles; DMEM_W_STB and PC_INC asserted only in the RDY cycle.
- Branch: CU_PC_LD_EN=1 in EXEC -> PC_LD=1, PC_INC=0 for exactly 1 cycle.
- Halt: CU_PC_EN=0 -> HALTED=1, no strobes, stays halted with RUN=1 until RST pulse returns IDLE, INST=8'h00.
- Watchdog: WDT_LIMIT=4, IMEM_VLD never asserted -> FAULT=1 after 4 FETCH cycles; VLD arriving in 4th cycle -> no fault.
- RUN dropped during MEM wait -> instruction commits on DMEM_RDY, then IDLE. With SEQ_SINGLE_STEP_EN: one STEP pulse yields exactly one PC_INC.
